// File: rtl/dbio_mailbox_ram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dbio_mailbox_ram_pkg                                       |
// | Function : Shared Dbio constants, mailbox mode encoding and helpers   |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package dbio_mailbox_ram_pkg;

   // Mailbox stream mode.
   typedef enum logic [1:0] {
      MODE_IDLE = 2'd0,
      MODE_WR   = 2'd1,
      MODE_RD   = 2'd2
   } mode_t;

   // Bytes in one Dbio word.
   localparam logic [3:0] DBIO_WORD_BYTES = 4'd8;

   // Default Dbio word base addresses of the targets behind the bridge.
   localparam logic [11:0] DBIO_BASE_MAILBOX = 12'h100;
   localparam logic [11:0] DBIO_BASE_ADC_LOG = 12'h700;

   // XOR of the bytes of a word selected by a byte mask.
   function automatic logic [7:0] masked_xor(input logic [63:0] word,
                                             input logic [7:0]  mask);
      logic [7:0] acc;
      acc = '0;
      for (int b = 0; b < 8; b++) begin
         if (mask[b]) acc = acc ^ word[8*b +: 8];
      end
      return acc;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dbio_mailbox_ram_byte_mask.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dbio_byte_mask                                             |
// | Function : Byte-count to byte-mask decoder with range classification  |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module dbio_byte_mask
   import dbio_mailbox_ram_pkg::*;
(
   input  logic [3:0] idx,
   output logic [7:0] mask,
   output logic       full,
   output logic       partial
);

   // Thermometer-decode the byte count; counts beyond a word select nothing.
   always_comb begin
      full    = (idx == DBIO_WORD_BYTES);
      partial = (idx != 4'd0) && (idx < DBIO_WORD_BYTES);
      mask    = '0;
      for (int b = 0; b < 8; b++) begin
         mask[b] = (idx <= DBIO_WORD_BYTES) && (4'(b) < idx);
      end
   end

endmodule
`default_nettype wire

// File: rtl/dbio_mailbox_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dbio_mailbox_ram                                           |
// | Function : Debugger-visible 64-bit word RAM on the Dbio bridge port,  |
// |            with a core-side read/write port and commit notification.  |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module dbio_mailbox_ram
   import dbio_mailbox_ram_pkg::*;
#(
   parameter int unsigned CAddrLen = 3,
   parameter logic [11:0] CBase    = DBIO_BASE_MAILBOX,
   parameter bit          CSbEcho  = 1'b0
) (
   input  logic                AClkH,
   input  logic                AResetHN,
   input  logic                AClkHEn,
   input  logic [11:0]         ADbioAddr,
   input  logic [63:0]         ADbioMosi,
   input  logic [3:0]          ADbioMosiIdx,
   input  logic [3:0]          ADbioMisoIdx,
   input  logic                ADbioMosi1st,
   input  logic                ADbioMiso1st,
   input  logic                ADbioDataLenNZ,
   output logic [63:0]         ADbioMiso,
   output logic                ADbioIdxReset,
   output logic [7:0]          ADbioSbData,
   output logic                ADbioSbNow,
   output logic                ADbioSbActive,
   input  logic [CAddrLen-1:0] AExtAddr,
   output logic [63:0]         AExtData,
   input  logic                AExtWrEn,
   input  logic [CAddrLen-1:0] AExtWrAddr,
   input  logic [63:0]         AExtWrData,
   output logic                AWrStrobe,
   output logic [CAddrLen-1:0] AWrAddr,
   output logic [7:0]          AWrMask
);

   localparam int unsigned CDepth = 1 << CAddrLen;

   mode_t               mode, mode_nxt;
   logic [CAddrLen-1:0] ptr, ptr_nxt;
   logic [CAddrLen-1:0] rd_cnt, rd_cnt_nxt;
   logic [CAddrLen-1:0] rd_addr;
   logic [7:0]          fxor, fxor_nxt;
   logic [63:0]         ram [CDepth];
   logic                hit;
   logic [7:0]          mosi_mask;
   logic                mosi_full, mosi_partial;
   logic                commit;
   logic                idx_rst, idx_rst_q;
   logic                stream_end;

   dbio_byte_mask u_mosi_mask (
      .idx     (ADbioMosiIdx),
      .mask    (mosi_mask),
      .full    (mosi_full),
      .partial (mosi_partial)
   );

   // Stream mode register with the write pointer, read counter and checksum.
   always_ff @(posedge AClkH or negedge AResetHN) begin
      if (!AResetHN) begin
         mode      <= MODE_IDLE;
         ptr       <= '0;
         rd_cnt    <= '0;
         fxor      <= '0;
         idx_rst_q <= 1'b0;
      end else if (AClkHEn) begin
         mode      <= mode_nxt;
         ptr       <= ptr_nxt;
         rd_cnt    <= rd_cnt_nxt;
         fxor      <= fxor_nxt;
         idx_rst_q <= idx_rst;
      end
   end

   // Next mode, commit decisions and bridge index reset.
   always_comb begin
      hit        = (ADbioAddr[11:CAddrLen] == CBase[11:CAddrLen]);
      mode_nxt   = mode;
      ptr_nxt    = ptr;
      rd_cnt_nxt = rd_cnt;
      fxor_nxt   = fxor;
      commit     = 1'b0;
      idx_rst    = 1'b0;
      stream_end = 1'b0;
      if (ADbioMosi1st || ADbioMiso1st) begin
         // Any start pulse restarts; a pending partial word is simply dropped.
         if (hit && ADbioMosi1st) begin
            mode_nxt = MODE_WR;
            ptr_nxt  = ADbioAddr[CAddrLen-1:0];
            fxor_nxt = '0;
         end else if (hit && ADbioMiso1st) begin
            mode_nxt   = MODE_RD;
            ptr_nxt    = ADbioAddr[CAddrLen-1:0];
            rd_cnt_nxt = '0;
         end else begin
            mode_nxt = MODE_IDLE;
         end
      end else begin
         case (mode)
            MODE_WR: begin
               // idx_rst_q keeps the index reset from firing on back-to-back cycles.
               if (mosi_full && !idx_rst_q) begin
                  commit  = 1'b1;
                  idx_rst = 1'b1;
                  ptr_nxt = ptr + CAddrLen'(1);
               end else if (mosi_partial && !ADbioDataLenNZ) begin
                  commit = 1'b1;
               end
               if (commit) fxor_nxt = fxor ^ masked_xor(ADbioMosi, mosi_mask);
               if (!ADbioDataLenNZ) begin
                  stream_end = 1'b1;
                  mode_nxt   = MODE_IDLE;
               end
            end
            MODE_RD: begin
               if ((ADbioMisoIdx == DBIO_WORD_BYTES) && !idx_rst_q) begin
                  idx_rst    = 1'b1;
                  rd_cnt_nxt = rd_cnt + CAddrLen'(1);
               end
               if (!ADbioDataLenNZ && (ADbioMisoIdx != DBIO_WORD_BYTES)) begin
                  mode_nxt = MODE_IDLE;
               end
            end
            default: ;
         endcase
      end
   end

   assign ADbioIdxReset = idx_rst & AClkHEn;

   // Read word: the start cycle serves the addressed word, later cycles look
   // one word ahead whenever the bridge is about to reload.
   always_comb begin
      rd_addr   = ptr + rd_cnt + CAddrLen'(idx_rst);
      ADbioMiso = '0;
      if (ADbioMiso1st) begin
         if (hit) ADbioMiso = ram[ADbioAddr[CAddrLen-1:0]];
      end else if (mode == MODE_RD) begin
         ADbioMiso = ram[rd_addr];
      end
   end

   // Side-band checksum pulse and registered commit notification.
   always_ff @(posedge AClkH or negedge AResetHN) begin
      if (!AResetHN) begin
         ADbioSbNow  <= 1'b0;
         ADbioSbData <= '0;
         AWrStrobe   <= 1'b0;
         AWrAddr     <= '0;
         AWrMask     <= '0;
      end else if (AClkHEn) begin
         ADbioSbNow <= CSbEcho && stream_end;
         if (CSbEcho && stream_end) ADbioSbData <= fxor_nxt;
         AWrStrobe <= commit;
         if (commit) begin
            AWrAddr <= ptr;
            AWrMask <= mosi_mask;
         end
      end
   end

   assign ADbioSbActive = CSbEcho && ((mode == MODE_WR) || ADbioSbNow);

   // RAM byte lanes: a Dbio commit owns its masked bytes, the core the rest.
   always_ff @(posedge AClkH or negedge AResetHN) begin
      if (!AResetHN) begin
         for (int w = 0; w < CDepth; w++) ram[w] <= '0;
      end else if (AClkHEn) begin
         for (int w = 0; w < CDepth; w++) begin
            for (int b = 0; b < 8; b++) begin
               if (commit && (ptr == CAddrLen'(w)) && mosi_mask[b]) begin
                  ram[w][8*b +: 8] <= ADbioMosi[8*b +: 8];
               end else if (AExtWrEn && (AExtWrAddr == CAddrLen'(w))) begin
                  ram[w][8*b +: 8] <= AExtWrData[8*b +: 8];
               end
            end
         end
      end
   end

   assign AExtData = ram[AExtAddr];

endmodule
`default_nettype wire

// File: doc/dbio_mailbox_ram.md
Name: dbio_mailbox_ram

Overview:
- Dbio target that sits directly downstream of the UART debug bridge, on its Dbio port.
- Holds a small 64-bit-word RAM that is visible to the debugger:
  - MOSI streams are assembled into words and written into the RAM.
  - MISO streams are served out of the RAM word by word.
  - The bridge's byte indices are re-armed through ADbioIdxReset.
- A core-side port gives the rest of the design a read port, a write port and write notifications.
- ADbioMiso and ADbioIdxReset drive zero on address miss, so several targets can be OR-combined.

Parameters:
- CAddrLen, 3: log2 of the RAM depth in 64-bit words (8 words by default).
- CBase, 12'h100: Dbio word base address. The block is selected when ADbioAddr[11:CAddrLen] == CBase[11:CAddrLen].
- CSbEcho, 0: when 1, the block sends a checksum byte on the side-band at the end of each write stream.

Ports:
- AClkH in 1: clock.
- AResetHN in 1: asynchronous active-low reset.
- AClkHEn in 1: clock enable. All registers hold while it is 0.
- ADbioAddr in 12: word address. It is valid when Mosi1st or Miso1st is high.
- ADbioMosi in 64: assembled MOSI bytes. Byte k is bits [8k+7:8k].
- ADbioMosiIdx in 4: number of MOSI bytes currently held.
- ADbioMisoIdx in 4: number of MISO bytes already sent from the current word.
- ADbioMosi1st in 1: one-cycle pulse marking the start of a write stream.
- ADbioMiso1st in 1: one-cycle pulse marking the start of a read stream.
- ADbioDataLenNZ in 1: high while stream bytes remain.
- ADbioMiso out 64: word to be loaded by the bridge. Combinational.
- ADbioIdxReset out 1: combinational pulse that reloads MISO and clears both bridge indices.
- ADbioSbData out 8: side-band byte.
- ADbioSbNow out 1: side-band byte strobe.
- ADbioSbActive out 1: side-band busy. It holds off the bridge's TX flush.
- AExtAddr in CAddrLen: core read address.
- AExtData out 64: core read data, RAM[AExtAddr]. Combinational.
- AExtWrEn in 1: core write enable.
- AExtWrAddr in CAddrLen: core write address.
- AExtWrData in 64: core write data.
- AWrStrobe out 1: registered pulse, one cycle after any Dbio write commit.
- AWrAddr out CAddrLen: address of that commit.
- AWrMask out 8: byte mask of that commit.

Behaviour:
- Reset values:
  - All RAM words are 0.
  - Mode is Idle.
  - FPtr, FRdCnt and FXor are 0.
  - All outputs are 0.
- State machine, mode register FMode in {Idle, Wr, Rd}:
  - Idle -> Wr on Mosi1st & hit. On entry: FPtr = ADbioAddr[CAddrLen-1:0], FXor = 0.
  - Idle -> Rd on Miso1st & hit. On entry: FPtr is latched the same way, FRdCnt = 0.
  - A 1st pulse without a hit forces Idle. This covers another target's stream.
  - A 1st pulse arriving in Wr or Rd restarts the stream. A pending partial word is discarded.
- Write commits (Wr mode):
  - Full word: when ADbioMosiIdx == 8.
    - ADbioIdxReset = 1 in that same cycle.
    - At the clock edge: RAM[FPtr] = ADbioMosi, FPtr += 1, and FPtr wraps modulo the depth.
  - Partial word: when ADbioDataLenNZ == 0 and MosiIdx is in 1..7.
    - Only bytes 0..MosiIdx-1 are written. The mask is (1 << idx) - 1.
    - Mode then goes to Idle.
  - When MosiIdx == 8 and DataLenNZ == 0 occur together, exactly one full commit happens, then Idle.
  - When MosiIdx == 0 and DataLenNZ == 0, the block goes to Idle with no commit.
  - MosiIdx values 9..15 are ignored: no commit and no IdxReset.
  - FXor accumulates the XOR of all 8 bytes of every committed word. For a partial commit, only the masked bytes are included.
- Side-band checksum (CSbEcho == 1):
  - SbActive is high for the whole of Wr mode.
  - The cycle after the final commit or end of the stream: SbNow = 1 for one cycle with SbData = FXor.
  - SbActive drops in the following cycle.
  - With CSbEcho == 0, all Sb outputs stay 0.
- Reads (Rd mode):
  - ADbioMiso = RAM[FPtr + FRdCnt] (modulo the depth) while in Rd. It is 0 otherwise.
  - When ADbioMisoIdx == 8:
    - ADbioIdxReset = 1 combinationally.
    - ADbioMiso is already RAM[FPtr + FRdCnt + 1].
    - At the edge, FRdCnt += 1.
  - The Miso1st cycle presents RAM[ADbioAddr] combinationally, because the bridge loads in that cycle.
  - Rd -> Idle when DataLenNZ == 0 and MisoIdx != 8.
- ADbioIdxReset is never asserted for two consecutive cycles; the index clears on the next edge.
- Core port:
  - AExtWrEn writes RAM[AExtWrAddr] = AExtWrData.
  - On a collision with a Dbio commit at the same address, Dbio wins for its masked bytes and the core wins for the remaining bytes.
  - AWrStrobe, AWrAddr and AWrMask are registered copies of the Dbio commit.
- Reset asserted mid-stream: mode returns to Idle immediately. Any partial word is lost.

Decomposition:
- Shared package constants:
  - Mode encoding: Idle = 2'd0, Wr = 2'd1, Rd = 2'd2.
  - Dbio word-size constant: 8 bytes.
  - Default base addresses of all Dbio targets, including 12'h700 reserved for the ADC log.
- One natural sub-module: dbio_byte_mask. It decodes a 4-bit index into an 8-bit byte mask and bounds-checks the index.

Test Plan:
1. Mosi1st at addr 0x102, 16 bytes 0x01..0x10 -> two IdxReset pulses; RAM[2] = 0x0807060504030201 and RAM[3] = 0x100F0E0D0C0B0A09; AWrStrobe twice.
2. Mosi1st at 0x107, 11 bytes -> full write to RAM[7], FPtr wraps to 0, partial write to RAM[0] with mask 0x07; upper bytes of RAM[0] unchanged.
3. Core writes RAM[5] = 0xA5..; Miso1st at 0x105, 16 bytes -> ADbioMiso = RAM[5] in the 1st cycle; at MisoIdx == 8, IdxReset = 1 and ADbioMiso = RAM[6].
4. Miso1st at 0x700 (miss) -> ADbioMiso = 0, IdxReset never asserted, mode stays Idle.
5. CSbEcho = 1, write of 0x11, 0x22, 0x44 -> SbNow pulses once with SbData = 0x77; SbActive spans from Mosi1st to SbNow.
6. AResetHN asserted after 5 of 8 MOSI bytes -> RAM is all zero, mode Idle, no AWrStrobe; a new stream after reset works normally.
